// File: rtl/decoder38_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
// Optional scan sequencer is enabled by DECODER38_SCAN_EN.
package decoder38_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic [7:0] DATA_INACTIVE_AL = 8'hFF;
   localparam logic [7:0] DATA_INACTIVE_AH = 8'h00;

   function automatic logic [7:0] onehot8(
      input logic [2:0] code,
      input logic       active_low
   );
      logic [7:0] v;
      v = 8'h01 << code;
      return active_low ? ~v : v;
   endfunction

   function automatic int unsigned cnt_width(
      input int unsigned hold
   );
      int unsigned w;
      w = $clog2(hold + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/decoder38_hold_counter.sv
// Loadable down-counter with zero flag, used to time the decoder hold.
// Saturates at zero so an extra decrement never wraps.
module hold_counter #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder38_hold.sv
// Registered 3-to-8 decoder holding each code for a minimum cycle count.
// Define DECODER38_SCAN_EN to add the iScan self-sequencing mode.
module decoder38_hold
   import decoder38_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [2:0] iData,
   input  logic       iEI,
   input  logic       iValid,
`ifdef DECODER38_SCAN_EN
   input  logic       iScan,
`endif
   output logic       oReady,
   output logic [7:0] oData,
   output logic [2:0] oCode,
   output logic       oEO,
   output logic       oBusy
);

   localparam int unsigned CW = cnt_width(HOLD_CYCLES);
   localparam int unsigned LOAD_INT =
      (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_INT);
   localparam logic [7:0] DATA_OFF =
      ACTIVE_LOW ? DATA_INACTIVE_AL : DATA_INACTIVE_AH;

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [2:0] code_q, code_d;
   logic       eo_q, eo_d;
   logic       cnt_load;
   logic       cnt_zero;
   logic       idle_free;

`ifdef DECODER38_SCAN_EN
   logic [2:0] scan_q, scan_d;
   // Scan pre-empts the handshake only when a new code could be issued.
   assign idle_free = (state_q == IDLE) && !iScan;
`else
   assign idle_free = (state_q == IDLE);
`endif

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      code_d   = code_q;
      eo_d     = eo_q;
      cnt_load = 1'b0;
`ifdef DECODER38_SCAN_EN
      scan_d   = scan_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef DECODER38_SCAN_EN
            if (iScan) begin
               code_d   = scan_q;
               eo_d     = 1'b0;
               data_d   = onehot8(scan_q, ACTIVE_LOW);
               scan_d   = scan_q + 3'd1;
               cnt_load = 1'b1;
               state_d  = HOLD;
            end else
`endif
            if (iValid) begin
               code_d   = iData;
               eo_d     = iEI;
               data_d   = iEI ? DATA_OFF
                              : onehot8(iData, ACTIVE_LOW);
               cnt_load = 1'b1;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         data_q  <= DATA_OFF;
         code_q  <= 3'b000;
         eo_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         code_q  <= code_d;
         eo_q    <= eo_d;
      end
   end

`ifdef DECODER38_SCAN_EN
   always_ff @(posedge iClk) begin
      if (iRst) begin
         scan_q <= 3'd0;
      end else begin
         scan_q <= scan_d;
      end
   end
`endif

   hold_counter #(
      .W(CW)
   ) u_hold (
      .clk     (iClk),
      .rst     (iRst),
      .load    (cnt_load),
      .load_val(LOAD_VAL),
      .dec     (state_q == HOLD),
      .zero    (cnt_zero)
   );

   assign oReady = idle_free;
   assign oBusy  = (state_q == HOLD);
   assign oData  = data_q;
   assign oCode  = code_q;
   assign oEO    = eo_q;

endmodule

// File: tb/tb_decoder38_hold.sv
// Scoreboard bench for decoder38_hold: default instance plus a
// HOLD_CYCLES=0 / active-high instance (scan mode under DECODER38_SCAN_EN).
module tb_decoder38_hold;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] i_data;
   logic       i_ei;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] o_data;
   logic [2:0] o_code;
   logic       o_eo;
   logic       o_busy;

   logic [2:0] i_data1;
   logic       i_ei1;
   logic       i_valid1;
   logic       o_ready1;
   logic [7:0] o_data1;
   logic [2:0] o_code1;
   logic       o_eo1;
   logic       o_busy1;
`ifdef DECODER38_SCAN_EN
   logic       scan0;
   logic       scan1;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic [2:0] code;
      logic       eo;
      int         hold;
      int         gap;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   decoder38_hold #(
      .HOLD_CYCLES(4),
      .ACTIVE_LOW (1'b1)
   ) u0 (
      .iClk  (clk),
      .iRst  (rst),
      .iData (i_data),
      .iEI   (i_ei),
      .iValid(i_valid),
`ifdef DECODER38_SCAN_EN
      .iScan (scan0),
`endif
      .oReady(o_ready),
      .oData (o_data),
      .oCode (o_code),
      .oEO   (o_eo),
      .oBusy (o_busy)
   );

   decoder38_hold #(
      .HOLD_CYCLES(0),
      .ACTIVE_LOW (1'b0)
   ) u1 (
      .iClk  (clk),
      .iRst  (rst),
      .iData (i_data1),
      .iEI   (i_ei1),
      .iValid(i_valid1),
`ifdef DECODER38_SCAN_EN
      .iScan (scan1),
`endif
      .oReady(o_ready1),
      .oData (o_data1),
      .oCode (o_code1),
      .oEO   (o_eo1),
      .oBusy (o_busy1)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: an accept shows up as oBusy rising.
   exp_t cur;
   int   run_len  = 0;
   int   idle_len = 0;
   bit   active   = 1'b0;
   logic busy_prev = 1'b0;

   always @(negedge clk) begin
      if (o_busy === 1'b1 && busy_prev !== 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got code %0d expected none",
                     o_code);
            cur = '{8'hFF, 3'd0, 1'b1, 0, -1};
         end else begin
            cur = q.pop_front();
            chk("data", 32'(o_data), 32'(cur.data));
            chk("code", 32'(o_code), 32'(cur.code));
            chk("eo", 32'(o_eo), 32'(cur.eo));
            if (cur.gap >= 0)
               chk("gap", 32'(idle_len), 32'(cur.gap));
         end
         run_len = 1;
         active  = 1'b1;
      end else if (o_busy === 1'b1) begin
         run_len++;
      end else begin
         if (active) begin
            chk("hold_len", 32'(run_len), 32'(cur.hold));
            active   = 1'b0;
            idle_len = 0;
         end
         idle_len++;
      end
      busy_prev = o_busy;
   end

   task automatic push(input logic [7:0] d, input logic [2:0] c,
                       input logic e, input int h, input int g);
      exp_t x;
      x = '{d, c, e, h, g};
      q.push_back(x);
   endtask

   // Present a code and wait (bounded) for the accepting edge.
   task automatic do_accept(input logic [2:0] c, input logic ei,
                            input bit keep);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      i_data  = c;
      i_ei    = ei;
      i_valid = 1'b1;
      while (!ok && n < 50) begin
         ok = (o_ready === 1'b1);
         @(posedge clk);
         n++;
      end
      #1;
      if (!keep) i_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no accept expected code %0d", c);
      end
   endtask

   initial begin
      int n;
      i_data   = 3'd0;
      i_ei     = 1'b0;
      i_valid  = 1'b1;
      i_data1  = 3'd0;
      i_ei1    = 1'b0;
      i_valid1 = 1'b0;
`ifdef DECODER38_SCAN_EN
      scan0 = 1'b0;
      scan1 = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      i_valid = 1'b0;
      @(negedge clk);
      chk("rst_data", 32'(o_data), 32'hFF);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_eo", 32'(o_eo), 32'd1);
      chk("rst_code", 32'(o_code), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst1_data", 32'(o_data1), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      push(8'b1101_1111, 3'd5, 1'b0, 4, -1);
      do_accept(3'd5, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;

      push(8'hFF, 3'd3, 1'b1, 4, -1);
      do_accept(3'd3, 1'b1, 1'b0);
      repeat (6) @(posedge clk);
      #1;

      push(8'hFE, 3'd0, 1'b0, 4, -1);
      push(8'h7F, 3'd7, 1'b0, 4, 1);
      do_accept(3'd0, 1'b0, 1'b1);
      do_accept(3'd7, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;

      push(8'hFB, 3'd2, 1'b0, 2, -1);
      do_accept(3'd2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_data", 32'(o_data), 32'hFF);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      chk("midrst_busy", 32'(o_busy), 32'd0);
      @(posedge clk);
      #1;
      push(8'hBF, 3'd6, 1'b0, 4, -1);
      do_accept(3'd6, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;

      // Zero-hold, active-high instance.
      chk("h0_ready_pre", 32'(o_ready1), 32'd1);
      i_data1  = 3'd4;
      i_ei1    = 1'b0;
      i_valid1 = 1'b1;
      @(posedge clk);
      #1;
      i_valid1 = 1'b0;
      @(negedge clk);
      chk("h0_data", 32'(o_data1), 32'h10);
      chk("h0_code", 32'(o_code1), 32'd4);
      chk("h0_ready_lo", 32'(o_ready1), 32'd0);
      @(negedge clk);
      chk("h0_ready_hi", 32'(o_ready1), 32'd1);
      chk("h0_data_held", 32'(o_data1), 32'h10);

`ifdef DECODER38_SCAN_EN
      begin
         int   got;
         logic bp;
         got = 0;
         bp  = o_busy1;
         @(posedge clk);
         #1;
         scan1 = 1'b1;
         n = 0;
         while (got < 9 && n < 60) begin
            @(negedge clk);
            n++;
            if (o_busy1 === 1'b1 && bp !== 1'b1) begin
               chk("scan_data", 32'(o_data1), 32'(8'h01 << (got % 8)));
               chk("scan_eo", 32'(o_eo1), 32'd0);
               got++;
            end
            bp = o_busy1;
         end
         chk("scan_count", 32'(got), 32'd9);
         @(posedge clk);
         #1;
         scan1 = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end
`endif

      n = 0;
      while ((q.size() != 0 || active) && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
